// File: rtl/epp_host_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// epp_host_ctrl_pkg : EPP command encodings and host FSM state codes
// Rev 1.0
// ============================================================================
package epp_host_ctrl_pkg;

  typedef enum logic [1:0] {
    EPP_AWR = 2'd0,
    EPP_ARD = 2'd1,
    EPP_DWR = 2'd2,
    EPP_DRD = 2'd3
  } epp_cmd_e;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  function automatic logic cmd_is_read(input logic [1:0] t);
    return t[0];
  endfunction

  function automatic logic cmd_is_data(input logic [1:0] t);
    return t[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/epp_host_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// epp_host_ctrl_sync2 : two-flop synchronizer, async active-low reset to 0
// Rev 1.0
// ============================================================================
module epp_host_ctrl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/epp_host_ctrl.sv
`default_nettype none
// ============================================================================
// epp_host_ctrl : EPP initiator turning single-byte commands into strobe cycles
// Rev 1.0
// ============================================================================
module epp_host_ctrl
  import epp_host_ctrl_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmdType,
  input  logic [7:0] cmdData,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       rspErr,
  output logic       EppAstb,
  output logic       EppDstb,
  output logic       EppWr,
  input  logic       EppWait,
  inout  wire  [7:0] DB
);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic             wait_s;
  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       cmd_type, cmd_type_d;
  logic [7:0]       cmd_data;
  logic             ready;
  logic             accept;
  logic             abort;
  logic             capture;
  logic             busy_d;
  logic             write_d;
  logic             db_oe;
  logic             astb, dstb, wr;
  logic             rsp_valid, rsp_err;
  logic [7:0]       rsp_data;

  epp_host_ctrl_sync2 u_wait_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (EppWait),
    .q     (wait_s)
  );

  // ready is only ever high in IDLE, so it alone qualifies the accept
  assign accept = cmdValid & ready;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cmd_type_d = cmd_type;
    abort      = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d    = S_SETUP;
          cmd_type_d = cmdType;
        end
      end
      S_SETUP: begin
        // a strobe may only fall once the peripheral has dropped Wait
        if (cnt >= SETUP_LAST && !wait_s) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_STROBE: begin
        if (wait_s) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          capture = cmd_is_read(cmd_type);
        end else if (cnt == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!wait_s) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign busy_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_RELEASE);
  assign write_d = busy_d && !cmd_is_read(cmd_type_d);

  // Bus outputs are registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cmd_type  <= 2'd0;
      cmd_data  <= 8'h00;
      ready     <= 1'b0;
      astb      <= 1'b1;
      dstb      <= 1'b1;
      wr        <= 1'b1;
      db_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cmd_type  <= cmd_type_d;
      if (accept) begin
        cmd_data <= cmdData;
      end
      ready     <= (state_d == S_IDLE);
      astb      <= !((state_d == S_STROBE) && !cmd_is_data(cmd_type_d));
      dstb      <= !((state_d == S_STROBE) &&  cmd_is_data(cmd_type_d));
      wr        <= !write_d;
      db_oe     <= write_d;
      rsp_valid <= abort || (state_d == S_DONE);
      rsp_err   <= abort;
      if (capture) begin
        rsp_data <= DB;
      end
    end
  end

  assign DB       = db_oe ? cmd_data : 8'hzz;
  assign cmdReady = ready;
  assign EppAstb  = astb;
  assign EppDstb  = dstb;
  assign EppWr    = wr;
  assign rspValid = rsp_valid;
  assign rspErr   = rsp_err;
  assign rspData  = rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_epp_host_ctrl.sv
`default_nettype none
// ============================================================================
// tb_epp_host_ctrl : EPP host bench with a peripheral/memory model and scoreboard
// Rev 1.0
// ============================================================================
module tb_epp_host_ctrl;
  import epp_host_ctrl_pkg::*;

  localparam int SETUP_CYC   = 2;
  localparam int TIMEOUT_CYC = 40;
  localparam int CNT_W       = 6;
  localparam int BUDGET      = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmdValid = 1'b0;
  logic [1:0] cmdType = 2'd0;
  logic [7:0] cmdData = 8'h00;
  logic       cmdReady, rspValid, rspErr;
  logic [7:0] rspData;
  logic       EppAstb, EppDstb, EppWr, EppWait;
  wire  [7:0] DB;

  int checks = 0;
  int failures = 0;

  // peripheral model state (written only by the peripheral process)
  logic       per_wait, per_oe;
  logic [7:0] per_dout, per_addr;
  logic [7:0] per_mem [256];
  int         lowcnt, highcnt;
  // peripheral controls (written only by the stimulus process)
  int         mode = 0;       // 0 normal, 1 never raises Wait, 2 Wait stuck high
  int         rise_dly = 1;
  int         fall_dly = 1;

  // scoreboard of what the peripheral should hold
  logic [7:0] exp_addr;
  logic [7:0] exp_mem [256];
  logic [7:0] exp_rsp;

  always #5 clk = ~clk;

  epp_host_ctrl #(
    .SETUP_CYC   (SETUP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdType  (cmdType),
    .cmdData  (cmdData),
    .rspValid (rspValid),
    .rspData  (rspData),
    .rspErr   (rspErr),
    .EppAstb  (EppAstb),
    .EppDstb  (EppDstb),
    .EppWr    (EppWr),
    .EppWait  (EppWait),
    .DB       (DB)
  );

  assign EppWait = per_wait;
  assign DB      = per_oe ? per_dout : 8'hzz;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 29 + 90);
  endfunction

  // EPP peripheral: Wait rises rise_dly clocks after a strobe falls, falls fall_dly after release
  always @(posedge clk) begin
    if (!rst_n) begin
      per_wait <= 1'b0;
      per_oe   <= 1'b0;
      per_dout <= 8'h00;
      per_addr <= 8'h00;
      lowcnt   <= 0;
      highcnt  <= 0;
      for (int i = 0; i < 256; i++) per_mem[i] <= pat(i);
    end else if (mode == 2) begin
      per_wait <= 1'b1;
      per_oe   <= 1'b0;
      lowcnt   <= 0;
      highcnt  <= 0;
    end else if (mode == 1) begin
      per_wait <= 1'b0;
      per_oe   <= 1'b0;
      lowcnt   <= 0;
      highcnt  <= 0;
    end else if (!EppAstb || !EppDstb) begin
      highcnt <= 0;
      if (!per_wait) begin
        if (lowcnt + 1 >= rise_dly) begin
          per_wait <= 1'b1;
          lowcnt   <= 0;
          if (!EppWr) begin
            if (!EppAstb) per_addr <= DB;
            else          per_mem[per_addr] <= DB;
          end else begin
            per_oe   <= 1'b1;
            per_dout <= !EppAstb ? per_addr : per_mem[per_addr];
          end
        end else begin
          lowcnt <= lowcnt + 1;
        end
      end
    end else begin
      lowcnt <= 0;
      if (per_wait) begin
        if (highcnt + 1 >= fall_dly) begin
          per_wait <= 1'b0;
          per_oe   <= 1'b0;
          highcnt  <= 0;
        end else begin
          highcnt <= highcnt + 1;
        end
      end
    end
  end

  task automatic model_reset();
    exp_addr = 8'h00;
    exp_rsp  = 8'h00;
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
  endtask

  // Issue one command and observe the bus until the response (no comparisons here)
  task automatic do_cmd(input logic [1:0] t, input logic [7:0] d,
                        output int lat, output logic err, output logic [7:0] rdata,
                        output logic a_low, output logic d_low, output int viol,
                        output logic bus_idle);
    int n;
    lat = 0; viol = 0; a_low = 1'b0; d_low = 1'b0; n = 0;
    @(negedge clk);
    cmdValid = 1'b1; cmdType = t; cmdData = d;
    while (!cmdReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) viol++;
    @(negedge clk);
    cmdValid = 1'b0;
    cmdData  = ~d;
    while (!rspValid && lat < BUDGET) begin
      if (!EppAstb) a_low = 1'b1;
      if (!EppDstb) d_low = 1'b1;
      if (!EppAstb && !EppDstb) viol++;
      if (EppWr !== cmd_is_read(t)) viol++;
      if (!cmd_is_read(t) && DB !== d) viol++;
      if (cmd_is_read(t) && dut.db_oe) viol++;
      if (cmdReady) viol++;
      @(negedge clk);
      lat++;
    end
    err      = rspErr;
    rdata    = rspData;
    bus_idle = EppAstb & EppDstb & EppWr & !dut.db_oe;
    @(negedge clk);
    if (rspValid) viol++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (EppAstb !== 1'b1) begin failures++; $display("FAIL rst_astb: got %b want 1", EppAstb); end
    checks++; if (EppDstb !== 1'b1) begin failures++; $display("FAIL rst_dstb: got %b want 1", EppDstb); end
    checks++; if (EppWr !== 1'b1) begin failures++; $display("FAIL rst_wr: got %b want 1", EppWr); end
    checks++; if (dut.db_oe !== 1'b0) begin failures++; $display("FAIL rst_db_drive: got %b want 0", dut.db_oe); end
    checks++; if (cmdReady !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", cmdReady); end
    checks++; if (rspValid !== 1'b0) begin failures++; $display("FAIL rst_rspvalid: got %b want 0", rspValid); end
    checks++; if (rspErr !== 1'b0) begin failures++; $display("FAIL rst_rsperr: got %b want 0", rspErr); end
    checks++; if (rspData !== 8'h00) begin failures++; $display("FAIL rst_rspdata: got %h want 00", rspData); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (cmdReady !== 1'b1) begin failures++; $display("FAIL rst_ready_after: got %b want 1", cmdReady); end
  endtask

  task automatic test_addr_write();
    int lat, viol; logic err, al, dl, idle; logic [7:0] rd;
    mode = 0; rise_dly = 3; fall_dly = 2;
    do_cmd(EPP_AWR, 8'h05, lat, err, rd, al, dl, viol, idle);
    exp_addr = 8'h05;
    checks++; if (lat !== SETUP_CYC + 3 + 2 + 6) begin failures++; $display("FAIL awr_latency: got %0d want %0d", lat, SETUP_CYC + 11); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL awr_err: got %b want 0", err); end
    checks++; if (al !== 1'b1 || dl !== 1'b0) begin failures++; $display("FAIL awr_strobe: astb_low=%b dstb_low=%b want 1/0", al, dl); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL awr_bus: got %0d protocol violations want 0", viol); end
    checks++; if (per_addr !== 8'h05) begin failures++; $display("FAIL awr_periph_addr: got %h want 05", per_addr); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL awr_done_bus: idle=%b want 1", idle); end
  endtask

  task automatic test_data_read();
    int lat, viol; logic err, al, dl, idle; logic [7:0] rd;
    mode = 0; rise_dly = 1; fall_dly = 4;
    do_cmd(EPP_DWR, 8'hA7, lat, err, rd, al, dl, viol, idle);
    exp_mem[exp_addr] = 8'hA7;
    rise_dly = 2; fall_dly = 3;
    do_cmd(EPP_DRD, 8'h5E, lat, err, rd, al, dl, viol, idle);
    exp_rsp = 8'hA7;
    checks++; if (rd !== 8'hA7) begin failures++; $display("FAIL drd_data: got %h want a7", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL drd_err: got %b want 0", err); end
    checks++; if (al !== 1'b0 || dl !== 1'b1) begin failures++; $display("FAIL drd_strobe: astb_low=%b dstb_low=%b want 0/1", al, dl); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL drd_bus: got %0d protocol violations want 0", viol); end
    checks++; if (lat !== SETUP_CYC + 2 + 3 + 6) begin failures++; $display("FAIL drd_latency: got %0d want %0d", lat, SETUP_CYC + 11); end
  endtask

  task automatic test_bram_write();
    int lat, viol; logic err, al, dl, idle; logic [7:0] rd;
    mode = 0; rise_dly = 2; fall_dly = 2;
    do_cmd(EPP_AWR, 8'h10, lat, err, rd, al, dl, viol, idle);
    exp_addr = 8'h10;
    do_cmd(EPP_DWR, 8'h3C, lat, err, rd, al, dl, viol, idle);
    exp_mem[8'h10] = 8'h3C;
    checks++; if (per_mem[8'h10] !== 8'h3C) begin failures++; $display("FAIL bram_word: got %h want 3c", per_mem[8'h10]); end
    checks++; if (rd !== exp_rsp) begin failures++; $display("FAIL bram_rsp_hold: got %h want %h", rd, exp_rsp); end
    do_cmd(EPP_ARD, 8'h00, lat, err, rd, al, dl, viol, idle);
    exp_rsp = exp_addr;
    checks++; if (rd !== 8'h10) begin failures++; $display("FAIL ard_data: got %h want 10", rd); end
  endtask

  task automatic test_timeout();
    int lat, viol; logic err, al, dl, idle; logic [7:0] rd;
    mode = 1;
    do_cmd(EPP_DWR, 8'h99, lat, err, rd, al, dl, viol, idle);
    checks++; if (lat !== SETUP_CYC + TIMEOUT_CYC) begin failures++; $display("FAIL to_latency: got %0d want %0d", lat, SETUP_CYC + TIMEOUT_CYC); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (rd !== exp_rsp) begin failures++; $display("FAIL to_rspdata: got %h want %h", rd, exp_rsp); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL to_bus_release: idle=%b want 1", idle); end
    checks++; if (dl !== 1'b1) begin failures++; $display("FAIL to_strobe: dstb_low=%b want 1", dl); end
    mode = 0; rise_dly = 2; fall_dly = 1;
    do_cmd(EPP_DRD, 8'h00, lat, err, rd, al, dl, viol, idle);
    exp_rsp = exp_mem[exp_addr];
    checks++; if (err !== 1'b0 || rd !== exp_rsp) begin failures++; $display("FAIL to_recover: err=%b data=%h want 0/%h", err, rd, exp_rsp); end
  endtask

  task automatic test_wait_stuck();
    int lat, viol; logic err, al, dl, idle; logic [7:0] rd;
    mode = 2;
    repeat (4) @(negedge clk);
    do_cmd(EPP_AWR, 8'hC3, lat, err, rd, al, dl, viol, idle);
    checks++; if (al !== 1'b0 || dl !== 1'b0) begin failures++; $display("FAIL stuck_strobe: astb_low=%b dstb_low=%b want 0/0", al, dl); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL stuck_err: got %b want 1", err); end
    checks++; if (lat !== TIMEOUT_CYC) begin failures++; $display("FAIL stuck_latency: got %0d want %0d", lat, TIMEOUT_CYC); end
    mode = 0; rise_dly = 1; fall_dly = 2;
    repeat (6) @(negedge clk);
    do_cmd(EPP_ARD, 8'h00, lat, err, rd, al, dl, viol, idle);
    exp_rsp = exp_addr;
    checks++; if (err !== 1'b0 || rd !== exp_addr) begin failures++; $display("FAIL stuck_recover: err=%b data=%h want 0/%h", err, rd, exp_addr); end
  endtask

  task automatic test_reset_mid_strobe();
    int n; logic saw_rsp;
    mode = 1; n = 0; saw_rsp = 1'b0;
    @(negedge clk);
    cmdValid = 1'b1; cmdType = EPP_DWR; cmdData = 8'h6B;
    while (!cmdReady && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmdValid = 1'b0;
    n = 0;
    while (EppDstb && n < 20) begin @(negedge clk); n++; end
    checks++; if (EppDstb !== 1'b0) begin failures++; $display("FAIL rmid_reach_strobe: dstb=%b want 0", EppDstb); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (EppDstb !== 1'b1) begin failures++; $display("FAIL rmid_dstb: got %b want 1", EppDstb); end
    checks++; if (EppWr !== 1'b1) begin failures++; $display("FAIL rmid_wr: got %b want 1", EppWr); end
    checks++; if (dut.db_oe !== 1'b0) begin failures++; $display("FAIL rmid_db_drive: got %b want 0", dut.db_oe); end
    checks++; if (cmdReady !== 1'b0) begin failures++; $display("FAIL rmid_ready: got %b want 0", cmdReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rspValid) saw_rsp = 1'b1;
    end
    rst_n = 1'b1;
    mode = 0;
    model_reset();
    @(negedge clk);
    if (rspValid) saw_rsp = 1'b1;
    checks++; if (saw_rsp !== 1'b0) begin failures++; $display("FAIL rmid_no_rsp: rspValid seen=%b want 0", saw_rsp); end
    checks++; if (cmdReady !== 1'b1) begin failures++; $display("FAIL rmid_ready_after: got %b want 1", cmdReady); end
    checks++; if (rspData !== 8'h00) begin failures++; $display("FAIL rmid_rspdata: got %h want 00", rspData); end
  endtask

  task automatic test_random();
    int lat, viol, exp_lat, bad; logic err, al, dl, idle; logic [7:0] rd, d;
    logic [1:0] t;
    mode = 0;
    for (int k = 0; k < 40; k++) begin
      t = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      rise_dly = $urandom_range(1, 6);
      fall_dly = $urandom_range(1, 6);
      exp_lat  = SETUP_CYC + rise_dly + fall_dly + 6;
      do_cmd(t, d, lat, err, rd, al, dl, viol, idle);
      case (t)
        EPP_AWR: exp_addr = d;
        EPP_DWR: exp_mem[exp_addr] = d;
        EPP_ARD: exp_rsp = exp_addr;
        default: exp_rsp = exp_mem[exp_addr];
      endcase
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, exp_lat); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_err[%0d]: got %b want 0", k, err); end
      checks++; if (rd !== exp_rsp) begin failures++; $display("FAIL rnd_rspdata[%0d]: got %h want %h", k, rd, exp_rsp); end
      checks++; if (viol !== 0 || al !== !cmd_is_data(t) || dl !== cmd_is_data(t)) begin
        failures++; $display("FAIL rnd_bus[%0d]: viol=%0d astb_low=%b dstb_low=%b type=%0d", k, viol, al, dl, t);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (per_mem[i] !== exp_mem[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_memory: got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_data_read();
    test_bram_write();
    test_timeout();
    test_wait_stuck();
    test_reset_mid_strobe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
